chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock,
//  carry held in a register between chunks. Trades latency for a short carry chain so wide
//  synth datapaths (phase accumulators, envelope math) close timing. Start/busy/done handshake.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK
//  CHUNK  8   bits added per cycle; NCHUNK = WIDTH/CHUNK (localparam), counter width clog2(NCHUNK)+1
// PORTS
//  clk     in   1      system clock, all logic on rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      request; sampled only in IDLE
//  sub     in   1      0: a+b+c_in ; 1: a-b (a + ~b + 1, c_in ignored)
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  c_in    in   1      carry in, captured on accepted start
//  busy    out  1      high while RUN
//  done    out  1      one-cycle pulse, result valid
//  sum     out  WIDTH  result; held until next done
//  c_out   out  1      carry out of MSB (sub: 1 = no borrow)
//  ovf     out  1      signed overflow (only with OVERFLOW_FLAG_EN)
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, chunk index=0.
//  - States: IDLE, RUN. IDLE & start -> RUN: latch a, b^{WIDTH{sub}}, carry=sub?1:c_in, idx=0.
//  - RUN, each edge: {carry, work[idx*CHUNK +: CHUNK]} = a_chunk + b_chunk + carry; idx++.
//  - Edge processing chunk NCHUNK-1: sum<=work (incl. final chunk), c_out<=carry out,
//    done<=1, state->IDLE. done cleared the following edge.
//  - Latency: start sampled on edge k -> done high after edge k+NCHUNK; busy high NCHUNK cycles.
//  - sum/c_out change only on the done edge; intermediate chunks never visible on sum.
//  - start while busy: ignored, no queueing. start during the done cycle: accepted (back-to-back,
//    throughput one result per NCHUNK cycles).
//  - Inputs a, b, c_in, sub may change freely after acceptance; only latched copies used.
//  - CHUNK==WIDTH: NCHUNK=1, single RUN cycle, done one cycle after start.
//  - Arithmetic is modulo 2^WIDTH; no saturation.
//  - Reset during RUN: operation aborted, no done pulse, outputs return to reset values.
//  - Reset has priority over start in the same cycle.
// CONFIGURATION
//  - OVERFLOW_FLAG_EN defined: port ovf present; on done edge ovf <= carry into MSB ^ carry out
//    of MSB (signed two's-complement overflow); held with sum; 0 at reset.
//  - Not defined: ovf port and its logic absent; all else identical.
// TESTING (WIDTH=32, CHUNK=8 unless stated)
//  1. a=FFFFFFFF b=00000001 c_in=0 sub=0, start -> busy 4 cycles, done after 4th edge, sum=0, c_out=1.
//  2. a=5 b=7 sub=1 -> sum=FFFFFFFE, c_out=0, ovf=0; a=7 b=5 sub=1 -> sum=2, c_out=1.
//  3. OVERFLOW_FLAG_EN: a=7FFFFFFF b=1 sub=0 -> sum=80000000, ovf=1, c_out=0.
//  4. start pulsed again at busy cycle 2 with a=1 b=1 -> ignored; result of first op unchanged, one done.
//  5. reset asserted at busy cycle 2 -> next cycle busy=0, done never pulses, sum=0; new start works.
//  6. WIDTH=16 CHUNK=16: a=1234 b=0001 c_in=1 -> done one cycle after start, sum=1236, c_out=0;
//     start held high on done cycle -> second op accepted immediately.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
// Optional OVERFLOW_FLAG_EN adds the signed-overflow output ovf.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             done_q, done_d;
  logic [CHUNK:0]   chunk_res;
  int               off;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      done_q  <= done_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    done_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    off       = int'(idx_q) * CHUNK;
    chunk_res = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the operand is inverted once at capture.
          state_d = S_RUN;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        work_d[off +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d              = chunk_res[CHUNK];
        idx_d                = idx_q + CW'(1);
        if (idx_q == CW'(NCHUNK - 1)) begin
          sum_d   = work_d;
          c_out_d = chunk_res[CHUNK];
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef OVERFLOW_FLAG_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
          ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_res[CHUNK-1]) ^ chunk_res[CHUNK];
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - directed self-checking bench for chunked_serial_adder
// Checks ovf only when OVERFLOW_FLAG_EN is defined.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, sub0, cin0, start1, sub1, cin1;
  logic [31:0] a0, b0;
  logic [15:0] a1, b1;
  logic        busy0, done0, co0, busy1, done1, co1;
  logic [31:0] sum0;
  logic [15:0] sum1;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf0, ovf1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lat, bcnt, ndone;
  logic stable;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .reset(reset), .start(start0), .sub(sub0), .a(a0), .b(b0), .c_in(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .c_out(co0)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf0)
`endif
  );

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(co1)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one op on u0; lat counts negedges from acceptance until done is seen.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic sb);
    logic [31:0] prev;
    prev = sum0;
    @(negedge clk);
    a0 = a; b0 = b; cin0 = ci; sub0 = sb; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    a0 = $urandom; b0 = $urandom; cin0 = ~ci; sub0 = ~sb;
    lat = 1; bcnt = busy0 ? 1 : 0; stable = (sum0 === prev);
    while (!done0 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy0) bcnt++;
      if (!done0 && sum0 !== prev) stable = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    start0 = 0; sub0 = 0; cin0 = 0; a0 = 0; b0 = 0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_sum", sum0, 0);
    chk("rst_cout", co0, 0);
    reset = 1'b0;

    // Wrap-around add across all chunks
    run32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk("t1_latency", lat, 5);
    chk("t1_busy_cycles", bcnt, 4);
    chk("t1_sum_stable", stable, 1);
    chk("t1_sum", sum0, 32'h0);
    chk("t1_cout", co0, 1);
    @(negedge clk);
    chk("t1_done_pulse", done0, 0);
    chk("t1_sum_held", sum0, 32'h0);

    run32(32'd5, 32'd7, 1'b0, 1'b1);
    chk("t2a_sum", sum0, 32'hFFFFFFFE);
    chk("t2a_cout", co0, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("t2a_ovf", ovf0, 0);
`endif
    run32(32'd7, 32'd5, 1'b1, 1'b1);
    chk("t2b_sum", sum0, 32'd2);
    chk("t2b_cout", co0, 1);

    run32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk("t3_sum", sum0, 32'h80000000);
    chk("t3_cout", co0, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("t3_ovf", ovf0, 1);
`endif

    run32(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0);
    chk("cin_sum", sum0, 32'h01000101);
    chk("cin_cout", co0, 0);
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    chk("ones_sum", sum0, 32'hFFFFFFFF);
    chk("ones_cout", co0, 1);

    // Start retriggered at busy cycle 2 must be ignored
    @(negedge clk);
    a0 = 32'h10203040; b0 = 32'h01010101; cin0 = 0; sub0 = 0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    a0 = 32'd1; b0 = 32'd1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done0) begin
        ndone++;
        chk("t4_sum", sum0, 32'h11213141);
      end
      @(negedge clk);
    end
    chk("t4_done_count", ndone, 1);
    chk("t4_sum_held", sum0, 32'h11213141);

    // Reset at busy cycle 2 aborts the op
    @(negedge clk);
    a0 = 32'd3; b0 = 32'd4; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", busy0, 0);
    chk("t5_sum", sum0, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done0) ndone++;
      @(negedge clk);
    end
    chk("t5_no_done", ndone, 0);
    run32(32'd3, 32'd4, 1'b0, 1'b0);
    chk("t5_restart_sum", sum0, 32'd7);

    // Reset wins over start in the same cycle
    @(negedge clk);
    reset = 1'b1; start0 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start0 = 1'b0;
    chk("rst_prio_busy", busy0, 0);
    chk("rst_prio_sum", sum0, 0);

    // Single-chunk instance with back-to-back start
    @(negedge clk);
    a1 = 16'h1234; b1 = 16'h0001; cin1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy1, 1);
    @(negedge clk);
    chk("t6_done", done1, 1);
    chk("t6_sum", sum1, 16'h1236);
    chk("t6_cout", co1, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("t6_ovf", ovf1, 0);
`endif
    a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    chk("t6_b2b_busy", busy1, 1);
    chk("t6_b2b_sum_held", sum1, 16'h1236);
    @(negedge clk);
    chk("t6_b2b_done", done1, 1);
    chk("t6_b2b_sum", sum1, 16'h0000);
    chk("t6_b2b_cout", co1, 1);
    @(negedge clk);
    chk("t6_idle", busy1 | done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
